// File: rtl/fp_align_if.sv
// fp_align_if: handshake and data bundle for the fp_align operand aligner.
//   Input side : in_valid / in_ready, packed operands a_i, b_i {sign, exp, mant}
//   Output side: out_valid / out_ready, aligned pair (signs, sub, exp,
//                big/small extended mantissas, inf flag)
//   modport master: the producer of operands and consumer of aligned pairs
//   modport slave : the aligner itself
interface fp_align_if #(
    parameter int EXPONENT = 8,
    parameter int MANTISSA = 23
);
    localparam int W  = MANTISSA + EXPONENT + 1;
    localparam int MW = MANTISSA + 3;

    logic                in_valid;
    logic                in_ready;
    logic [W-1:0]        a_i;
    logic [W-1:0]        b_i;
    logic                out_valid;
    logic                out_ready;
    logic                out_sign_big;
    logic                out_sign_small;
    logic                out_sub;
    logic [EXPONENT-1:0] out_exp;
    logic [MW-1:0]       out_mant_big;
    logic [MW-1:0]       out_mant_small;
    logic                out_inf;

    modport master (
        output in_valid, a_i, b_i, out_ready,
        input  in_ready, out_valid, out_sign_big, out_sign_small, out_sub,
               out_exp, out_mant_big, out_mant_small, out_inf
    );

    modport slave (
        input  in_valid, a_i, b_i, out_ready,
        output in_ready, out_valid, out_sign_big, out_sign_small, out_sub,
               out_exp, out_mant_big, out_mant_small, out_inf
    );
endinterface

// File: rtl/fp_align.sv
// fp_align: front end of the FP adder. Unpacks two packed operands, restores
// the hidden bit (zero exponent flushes the operand to zero), orders them so
// the larger magnitude is "big", and right-shifts the small mantissa by the
// exponent difference. Extended mantissas carry 2 guard bits.
// Two pipeline stages with valid/ready on both sides, no skid buffer.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : fp_align_if.slave (operand input handshake, aligned output)
// Optional feature macro FP_ALIGN_STICKY_EN: when defined, bits shifted out
// of the small mantissa are ORed into bit 0 of out_mant_small.
module fp_align #(
    parameter int EXPONENT = 8,
    parameter int MANTISSA = 23
) (
    input  logic        clk,
    input  logic        rst,
    fp_align_if.slave   bus
);
    localparam int W  = MANTISSA + EXPONENT + 1;
    localparam int MW = MANTISSA + 3;

    typedef logic [MW-1:0]       mant_t;
    typedef logic [EXPONENT-1:0] expo_t;

    // stage 1 registers
    logic  v1_q, v1_d;
    logic  sign_big1_q, sign_big1_d;
    logic  sign_small1_q, sign_small1_d;
    expo_t exp1_q, exp1_d;
    expo_t diff1_q, diff1_d;
    mant_t mb1_q, mb1_d;
    mant_t ms1_q, ms1_d;
    logic  inf1_q, inf1_d;

    // stage 2 registers (drive the outputs directly)
    logic  v2_q, v2_d;
    logic  sign_big2_q, sign_big2_d;
    logic  sign_small2_q, sign_small2_d;
    logic  sub2_q, sub2_d;
    expo_t exp2_q, exp2_d;
    mant_t mb2_q, mb2_d;
    mant_t ms2_q, ms2_d;
    logic  inf2_q, inf2_d;

    logic adv1, adv2;

    // unpack / compare
    logic                sign_a, sign_b;
    expo_t               exp_a, exp_b;
    logic [MANTISSA-1:0] man_a, man_b;
    logic                zero_a, zero_b;
    mant_t               ext_a, ext_b;
    logic                a_big;

    // stage 2 shift
    mant_t shifted;
    mant_t lost;
    logic  sat;
    mant_t ms_aligned;

    assign adv2 = !v2_q | bus.out_ready;
    assign adv1 = !v1_q | adv2;
    assign bus.in_ready = adv1;

    always_comb begin
        sign_a = bus.a_i[W-1];
        sign_b = bus.b_i[W-1];
        exp_a  = bus.a_i[W-2 -: EXPONENT];
        exp_b  = bus.b_i[W-2 -: EXPONENT];
        zero_a = (exp_a == '0);
        zero_b = (exp_b == '0);
        // denormals are flushed: a zero exponent wipes the fraction too
        man_a  = zero_a ? '0 : bus.a_i[MANTISSA-1:0];
        man_b  = zero_b ? '0 : bus.b_i[MANTISSA-1:0];
        ext_a  = {~zero_a, man_a, 2'b00};
        ext_b  = {~zero_b, man_b, 2'b00};
        // ties resolve to A as the big operand
        a_big  = {exp_a, man_a} >= {exp_b, man_b};
    end

    always_comb begin
        sat     = 32'(diff1_q) >= MW;
        shifted = ms1_q >> diff1_q;
        lost    = ms1_q & ~({MW{1'b1}} << diff1_q);
`ifdef FP_ALIGN_STICKY_EN
        ms_aligned = sat ? mant_t'(|ms1_q) : (shifted | mant_t'(|lost));
`else
        ms_aligned = sat ? '0 : shifted;
`endif
    end

    always_comb begin
        v1_d          = v1_q;
        sign_big1_d   = sign_big1_q;
        sign_small1_d = sign_small1_q;
        exp1_d        = exp1_q;
        diff1_d       = diff1_q;
        mb1_d         = mb1_q;
        ms1_d         = ms1_q;
        inf1_d        = inf1_q;

        v2_d          = v2_q;
        sign_big2_d   = sign_big2_q;
        sign_small2_d = sign_small2_q;
        sub2_d        = sub2_q;
        exp2_d        = exp2_q;
        mb2_d         = mb2_q;
        ms2_d         = ms2_q;
        inf2_d        = inf2_q;

        if (adv1) begin
            v1_d = bus.in_valid;
            if (bus.in_valid) begin
                sign_big1_d   = a_big ? sign_a : sign_b;
                sign_small1_d = a_big ? sign_b : sign_a;
                exp1_d        = a_big ? exp_a  : exp_b;
                diff1_d       = a_big ? (exp_a - exp_b) : (exp_b - exp_a);
                mb1_d         = a_big ? ext_a  : ext_b;
                ms1_d         = a_big ? ext_b  : ext_a;
                inf1_d        = (&exp_a) | (&exp_b);
            end
        end

        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                sign_big2_d   = sign_big1_q;
                sign_small2_d = sign_small1_q;
                sub2_d        = sign_big1_q ^ sign_small1_q;
                exp2_d        = exp1_q;
                mb2_d         = mb1_q;
                ms2_d         = ms_aligned;
                inf2_d        = inf1_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q          <= 1'b0;
            sign_big1_q   <= 1'b0;
            sign_small1_q <= 1'b0;
            exp1_q        <= '0;
            diff1_q       <= '0;
            mb1_q         <= '0;
            ms1_q         <= '0;
            inf1_q        <= 1'b0;
            v2_q          <= 1'b0;
            sign_big2_q   <= 1'b0;
            sign_small2_q <= 1'b0;
            sub2_q        <= 1'b0;
            exp2_q        <= '0;
            mb2_q         <= '0;
            ms2_q         <= '0;
            inf2_q        <= 1'b0;
        end else begin
            v1_q          <= v1_d;
            sign_big1_q   <= sign_big1_d;
            sign_small1_q <= sign_small1_d;
            exp1_q        <= exp1_d;
            diff1_q       <= diff1_d;
            mb1_q         <= mb1_d;
            ms1_q         <= ms1_d;
            inf1_q        <= inf1_d;
            v2_q          <= v2_d;
            sign_big2_q   <= sign_big2_d;
            sign_small2_q <= sign_small2_d;
            sub2_q        <= sub2_d;
            exp2_q        <= exp2_d;
            mb2_q         <= mb2_d;
            ms2_q         <= ms2_d;
            inf2_q        <= inf2_d;
        end
    end

    assign bus.out_valid      = v2_q;
    assign bus.out_sign_big   = sign_big2_q;
    assign bus.out_sign_small = sign_small2_q;
    assign bus.out_sub        = sub2_q;
    assign bus.out_exp        = exp2_q;
    assign bus.out_mant_big   = mb2_q;
    assign bus.out_mant_small = ms2_q;
    assign bus.out_inf        = inf2_q;
endmodule

// File: tb/tb_fp_align.sv
module tb_fp_align;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_align_if #(.EXPONENT(8), .MANTISSA(23)) bus ();

    fp_align #(.EXPONENT(8), .MANTISSA(23)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef FP_ALIGN_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    typedef struct {
        string       name;
        logic        sb;
        logic        ss;
        logic        sub;
        logic [7:0]  ex;
        logic [25:0] mb;
        logic [25:0] ms;
        logic        inf;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_out    = 0;

    function automatic exp_t mk(input string name, input logic sb, input logic ss,
                                input logic sub, input logic [7:0] ex,
                                input logic [25:0] mb, input logic [25:0] ms,
                                input logic inf);
        exp_t e;
        e.name = name; e.sb = sb; e.ss = ss; e.sub = sub;
        e.ex = ex; e.mb = mb; e.ms = ms; e.inf = inf;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // monitor: compares the head of the scoreboard whenever output is valid;
    // pops only on an actual transfer, so stalled cycles re-check stability
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output exp=%h mb=%h ms=%h want=none",
                         bus.out_exp, bus.out_mant_big, bus.out_mant_small);
            end else begin
                check(sb_q[0].name,
                      {2'b0, bus.out_sign_big, bus.out_sign_small, bus.out_sub, bus.out_exp,
                       bus.out_mant_big, bus.out_mant_small, bus.out_inf},
                      {2'b0, sb_q[0].sb, sb_q[0].ss, sb_q[0].sub, sb_q[0].ex,
                       sb_q[0].mb, sb_q[0].ms, sb_q[0].inf});
                if (bus.out_ready) begin
                    void'(sb_q.pop_front());
                    n_out++;
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input exp_t e);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.a_i = a;
        bus.b_i = b;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout %s in_ready=0 want=1", e.name);
        end else begin
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int outs_before;
        bus.in_valid  = 1'b0;
        bus.a_i       = '0;
        bus.b_i       = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_data", {2'b0, bus.out_sign_big, bus.out_sign_small, bus.out_sub,
                             bus.out_exp, bus.out_mant_big, bus.out_mant_small,
                             bus.out_inf}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(32'h3F800000, 32'h40000000,
             mk("one_two", 0, 0, 0, 8'h80, 26'h2000000, 26'h1000000, 0));
        send(32'h40000000, 32'hBF800000,
             mk("two_neg_one", 0, 1, 1, 8'h80, 26'h2000000, 26'h1000000, 0));
        send(32'h3F800001, 32'h30800000,
             mk("diff30", 0, 0, 0, 8'h7F, 26'h2000004, STICKY ? 26'h1 : 26'h0, 0));
        send(32'h00000000, 32'h3F800000,
             mk("zero_a", 0, 0, 0, 8'h7F, 26'h2000000, 26'h0, 0));
        send(32'h7F800000, 32'h3F800000,
             mk("inf_a", 0, 0, 0, 8'hFF, 26'h2000000, STICKY ? 26'h1 : 26'h0, 1));
        send(32'hBF800000, 32'hBF800000,
             mk("tie_neg", 1, 1, 0, 8'h7F, 26'h2000000, 26'h2000000, 0));
        send(32'h3F800000, 32'h33000000,
             mk("diff25", 0, 0, 0, 8'h7F, 26'h2000000, 26'h1, 0));
        send(32'h3F800000, 32'h32800000,
             mk("diff26", 0, 0, 0, 8'h7F, 26'h2000000, STICKY ? 26'h1 : 26'h0, 0));
        send(32'h3F800000, 32'h3E000001,
             mk("diff3_lost", 0, 0, 0, 8'h7F, 26'h2000000,
                STICKY ? 26'h0400001 : 26'h0400000, 0));
        send(32'h00000000, 32'h80000000,
             mk("both_zero", 0, 1, 1, 8'h00, 26'h0, 26'h0, 0));
        drain();

        // back-to-back stream with a 3-cycle downstream stall
        bus.out_ready = 1'b0;
        fork
            begin
                send(32'h3F800000, 32'h3F800000,
                     mk("strm0", 0, 0, 0, 8'h7F, 26'h2000000, 26'h2000000, 0));
                send(32'h3F800000, 32'h3F000000,
                     mk("strm1", 0, 0, 0, 8'h7F, 26'h2000000, 26'h1000000, 0));
                send(32'h3F800000, 32'h3E800000,
                     mk("strm2", 0, 0, 0, 8'h7F, 26'h2000000, 26'h0800000, 0));
                send(32'h3F800000, 32'h3E000000,
                     mk("strm3", 0, 0, 0, 8'h7F, 26'h2000000, 26'h0400000, 0));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                check("stall_in_ready", 64'(bus.in_ready), 64'd0);
                check("stall_out_valid", 64'(bus.out_valid), 64'd1);
                bus.out_ready = 1'b1;
            end
        join
        outs_before = n_out;
        drain();
        check("stream_count", 64'(n_out - outs_before), 64'd2);

        // reset with two pairs in flight
        send(32'h3F800000, 32'h40000000,
             mk("rst_p0", 0, 0, 0, 8'h80, 26'h2000000, 26'h1000000, 0));
        send(32'h40000000, 32'hBF800000,
             mk("rst_p1", 0, 1, 1, 8'h80, 26'h2000000, 26'h1000000, 0));
        rst = 1'b1;
        sb_q.delete();
        outs_before = n_out;
        #1;
        check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_after_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (6) @(posedge clk);
        #1;
        check("rst_no_stale", 64'(n_out - outs_before), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
